// File: rtl/sparc_exu_byp_eccarb.sv
// sparc_exu_byp_eccarb
//   Shares one two-stage bypass ECC generator among NREQ requesters.
//   A round-robin arbiter picks one requester per cycle and steers its
//   data/mask into the generator. A stage-1 register shadows the
//   generator's internal flop so the returning check bits can be paired
//   with their data, source and tag. A small FIFO then holds the results
//   for the consumer under valid/ready flow control.
//
// Ports
//   clk, rst_l          clock, synchronous active-low reset
//   req_vld/data/msk/tag per-requester request (held until granted)
//   req_gnt             one-hot grant, combinational, in the issue cycle
//   ecc_d, ecc_msk      to generator d/msk (zero when nothing issues)
//   ecc_p               from generator p, valid one cycle after issue
//   out_vld/rdy         result handshake at the buffer head
//   out_p/data/src/tag  head entry contents (zero when empty)
//   busy                something in flight or buffered

// Per-requester steering: gates the requester's fields with its grant so
// the top can OR all lanes together into the generator inputs.
module sparc_exu_byp_eccarb_lane #(
  parameter int TAG_W = 5
) (
  input  logic             gnt,
  input  logic [63:0]      data,
  input  logic [7:0]       msk,
  input  logic [TAG_W-1:0] tag,
  output logic [63:0]      d_sel,
  output logic [7:0]       msk_sel,
  output logic [TAG_W-1:0] tag_sel
);
  assign d_sel   = data & {64{gnt}};
  assign msk_sel = msk & {8{gnt}};
  assign tag_sel = tag & {TAG_W{gnt}};
endmodule

module sparc_exu_byp_eccarb #(
  parameter int NREQ      = 4,
  parameter int TAG_W     = 5,
  parameter int SRC_W     = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [NREQ-1:0]            req_vld,
  input  logic [NREQ-1:0][63:0]      req_data,
  input  logic [NREQ-1:0][7:0]       req_msk,
  input  logic [NREQ-1:0][TAG_W-1:0] req_tag,
  output logic [NREQ-1:0]            req_gnt,
  output logic [63:0]                ecc_d,
  output logic [7:0]                 ecc_msk,
  input  logic [7:0]                 ecc_p,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [7:0]                 out_p,
  output logic [63:0]                out_data,
  output logic [SRC_W-1:0]           out_src,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       busy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [7:0]       p;
    logic [63:0]      data;
    logic [SRC_W-1:0] src;
    logic [TAG_W-1:0] tag;
  } ent_t;

  // ---------------- state ----------------
  logic [SRC_W-1:0] rr_ptr;
  logic             s1_vld;
  logic [63:0]      s1_data;
  logic [SRC_W-1:0] s1_src;
  logic [TAG_W-1:0] s1_tag;

  ent_t             mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;

  // ---------------- arbitration ----------------
  logic [NREQ-1:0]  rot;
  logic [SRC_W-1:0] win;
  logic             win_ok;
  logic             room;
  logic             issue;
  logic             push, pop;
  int               win_idx;

  assign out_vld = (cnt != '0);
  assign pop     = out_vld & out_rdy;
  assign push    = s1_vld;

  // Space check counts the in-flight result and credits a same-cycle pop,
  // which is what lets grants resume in the cycle the consumer drains.
  assign room  = (int'(cnt) + int'(s1_vld) - int'(pop)) < BUF_DEPTH;
  assign issue = rst_l & win_ok & room;

  // rot[j] is requester (rr_ptr+1+j) mod NREQ; the lowest set bit wins.
  always_comb begin
    rot     = NREQ'({req_vld, req_vld} >> ({1'b0, rr_ptr} + 1'b1));
    win     = '0;
    win_ok  = 1'b0;
    win_idx = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win_ok  = 1'b1;
        win_idx = int'(rr_ptr) + 1 + j;
        if (win_idx >= NREQ) win_idx = win_idx - NREQ;
        win     = SRC_W'(win_idx);
      end
    end
  end

  always_comb begin
    req_gnt = '0;
    for (int i = 0; i < NREQ; i++)
      req_gnt[i] = issue && (win == SRC_W'(i));
  end

  // ---------------- steering ----------------
  logic [NREQ-1:0][63:0]      lane_d;
  logic [NREQ-1:0][7:0]       lane_msk;
  logic [NREQ-1:0][TAG_W-1:0] lane_tag;
  logic [TAG_W-1:0]           sel_tag;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    sparc_exu_byp_eccarb_lane #(.TAG_W(TAG_W)) u_lane (
      .gnt     (req_gnt[i]),
      .data    (req_data[i]),
      .msk     (req_msk[i]),
      .tag     (req_tag[i]),
      .d_sel   (lane_d[i]),
      .msk_sel (lane_msk[i]),
      .tag_sel (lane_tag[i])
    );
  end

  always_comb begin
    ecc_d   = '0;
    ecc_msk = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      ecc_d   = ecc_d | lane_d[i];
      ecc_msk = ecc_msk | lane_msk[i];
      sel_tag = sel_tag | lane_tag[i];
    end
  end

  // ---------------- stage 1 (shadows the generator flop) ----------------
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_src  <= '0;
      s1_tag  <= '0;
      rr_ptr  <= SRC_W'(NREQ - 1);
    end else begin
      s1_vld <= issue;
      if (issue) begin
        s1_data <= ecc_d;
        s1_src  <= win;
        s1_tag  <= sel_tag;
        rr_ptr  <= win;
      end
    end
  end

  // ---------------- result buffer ----------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset: validity lives in cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{p: ecc_p, data: s1_data, src: s1_src, tag: s1_tag};
  end

  ent_t head;
  assign head     = mem[rd_ptr];
  assign out_p    = out_vld ? head.p    : '0;
  assign out_data = out_vld ? head.data : '0;
  assign out_src  = out_vld ? head.src  : '0;
  assign out_tag  = out_vld ? head.tag  : '0;

  assign busy = s1_vld | out_vld;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(push && (cnt == CNT_W'(BUF_DEPTH)) && !pop));

endmodule
